// File: rtl/eth_tx_arbiter.sv
// Two-port Ethernet TX packet arbiter plus Avalon-ST mux; data path latency 1 cycle (registered dout_*).
// din_ready_x follows dout_ready combinationally; sources gate on their own grant.
module eth_tx_arbiter #(
    parameter int unsigned GAP_CYCLES    = 2,
    parameter logic [15:0] GRANT_TIMEOUT = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  arbit_request_0,
    input  logic [1:0]  arbit_request_1,
    output logic        arbit_grant_0,
    output logic        arbit_grant_1,
    input  logic        arbit_eop_0,
    input  logic        arbit_eop_1,
    output logic        din_ready_0,
    output logic        din_ready_1,
    input  logic        din_sop_0,
    input  logic        din_eop_0,
    input  logic        din_valid_0,
    input  logic [63:0] din_data_0,
    input  logic [2:0]  din_empty_0,
    input  logic        din_error_0,
    input  logic        din_sop_1,
    input  logic        din_eop_1,
    input  logic        din_valid_1,
    input  logic [63:0] din_data_1,
    input  logic [2:0]  din_empty_1,
    input  logic        din_error_1,
    input  logic        dout_ready,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        dout_valid,
    output logic [63:0] dout_data,
    output logic [2:0]  dout_empty,
    output logic        dout_error,
    output logic        timeout_err,
    output logic        drop_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_0, OWN_1} owner_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    logic [1:0]  r_req_0;
    logic [1:0]  r_req_1;
    logic        r_rr_ptr;
    logic        r_ever_gnt;
    logic [3:0]  r_gap_cnt;
    logic [15:0] r_to_cnt;
    logic        r_timeout_err;
    logic        r_drop_err;
    logic        r_dout_sop;
    logic        r_dout_eop;
    logic        r_dout_valid;
    logic [63:0] r_dout_data;
    logic [2:0]  r_dout_empty;
    logic        r_dout_error;

    logic [1:0]  w_lvl_0;
    logic [1:0]  w_lvl_1;
    logic        w_any_req;
    logic        w_winner;
    logic        w_own_eop;
    logic        w_timeout;
    logic        w_gap_done;

    // Level 2 is folded onto normal; urgent maps to the top level.
    function automatic logic [1:0] f_lvl(input logic [1:0] req);
        return (req == 2'd3) ? 2'd2 : ((req != 2'd0) ? 2'd1 : 2'd0);
    endfunction

    assign w_lvl_0    = f_lvl(r_req_0);
    assign w_lvl_1    = f_lvl(r_req_1);
    assign w_any_req  = (w_lvl_0 != 2'd0) || (w_lvl_1 != 2'd0);
    assign w_winner   = (w_lvl_0 > w_lvl_1) ? 1'b0 :
                        (w_lvl_1 > w_lvl_0) ? 1'b1 : ~r_rr_ptr;
    assign w_own_eop  = r_rr_ptr ? arbit_eop_1 : arbit_eop_0;
    assign w_timeout  = (r_to_cnt == GRANT_TIMEOUT - 16'd1);
    assign w_gap_done = (r_gap_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_state_nxt = ST_GRANT;
            ST_GRANT: if (w_own_eop || w_timeout) w_state_nxt = ST_GAP;
            ST_GAP:   if (w_gap_done) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        arbit_grant_0 = (r_state == ST_GRANT) && !r_rr_ptr;
        arbit_grant_1 = (r_state == ST_GRANT) &&  r_rr_ptr;
    end

    // rr_ptr doubles as the granted port while in GRANT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_0       <= 2'd0;
            r_req_1       <= 2'd0;
            r_rr_ptr      <= 1'b0;
            r_ever_gnt    <= 1'b0;
            r_to_cnt      <= 16'd0;
            r_gap_cnt     <= 4'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_req_0 <= arbit_request_0;
            r_req_1 <= arbit_request_1;
            if (r_state == ST_IDLE && w_any_req) begin
                r_rr_ptr   <= w_winner;
                r_ever_gnt <= 1'b1;
                r_to_cnt   <= 16'd0;
            end else if (r_state == ST_GRANT) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
            if (r_state == ST_GRANT) r_gap_cnt <= 4'd0;
            else if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + 4'd1;
            if (r_state == ST_GRANT && !w_own_eop && w_timeout) r_timeout_err <= 1'b1;
        end
    end

    assign din_ready_0 = dout_ready;
    assign din_ready_1 = dout_ready;

    logic        w_acc_0;
    logic        w_acc_1;
    logic        w_take_0;
    logic        w_take_1;
    logic        w_sel_vld;
    logic        w_sel_port;
    logic        w_sel_sop;
    logic        w_sel_eop;
    logic        w_sel_valid;
    logic [63:0] w_sel_data;
    logic [2:0]  w_sel_empty;
    logic        w_sel_error;
    logic        w_drop;

    // Ownership follows the packet, not the grant: data trails its grant by several cycles.
    assign w_acc_0    = din_valid_0 && dout_ready;
    assign w_acc_1    = din_valid_1 && dout_ready;
    assign w_take_0   = (r_owner == OWN_NONE) && w_acc_0 && din_sop_0 && r_ever_gnt && !r_rr_ptr;
    assign w_take_1   = (r_owner == OWN_NONE) && w_acc_1 && din_sop_1 && r_ever_gnt &&  r_rr_ptr;
    assign w_sel_vld  = (r_owner != OWN_NONE) || w_take_0 || w_take_1;
    assign w_sel_port = (r_owner == OWN_1) || w_take_1;
    assign w_drop     = (w_acc_0 && (r_owner != OWN_0) && !w_take_0) ||
                        (w_acc_1 && (r_owner != OWN_1) && !w_take_1);

    always_comb begin
        w_sel_sop   = din_sop_0;
        w_sel_eop   = din_eop_0;
        w_sel_valid = din_valid_0;
        w_sel_data  = din_data_0;
        w_sel_empty = din_empty_0;
        w_sel_error = din_error_0;
        if (w_sel_port) begin
            w_sel_sop   = din_sop_1;
            w_sel_eop   = din_eop_1;
            w_sel_valid = din_valid_1;
            w_sel_data  = din_data_1;
            w_sel_empty = din_empty_1;
            w_sel_error = din_error_1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner      <= OWN_NONE;
            r_drop_err   <= 1'b0;
            r_dout_sop   <= 1'b0;
            r_dout_eop   <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_data  <= 64'd0;
            r_dout_empty <= 3'd0;
            r_dout_error <= 1'b0;
        end else begin
            if (w_sel_vld && w_sel_valid && dout_ready && w_sel_eop) r_owner <= OWN_NONE;
            else if (w_take_0) r_owner <= OWN_0;
            else if (w_take_1) r_owner <= OWN_1;
            if (w_drop) r_drop_err <= 1'b1;
            if (w_sel_vld) begin
                r_dout_sop   <= w_sel_sop;
                r_dout_eop   <= w_sel_eop;
                r_dout_valid <= w_sel_valid && dout_ready;
                r_dout_data  <= w_sel_data;
                r_dout_empty <= w_sel_empty;
                r_dout_error <= w_sel_error;
            end else begin
                r_dout_sop   <= 1'b0;
                r_dout_eop   <= 1'b0;
                r_dout_valid <= 1'b0;
                r_dout_data  <= 64'd0;
                r_dout_empty <= 3'd0;
                r_dout_error <= 1'b0;
            end
        end
    end

    assign dout_sop    = r_dout_sop;
    assign dout_eop    = r_dout_eop;
    assign dout_valid  = r_dout_valid;
    assign dout_data   = r_dout_data;
    assign dout_empty  = r_dout_empty;
    assign dout_error  = r_dout_error;
    assign timeout_err = r_timeout_err;
    assign drop_err    = r_drop_err;

endmodule
